// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS phase accumulator.
// Ports: clk, rst_n | start, abort, sweep config in | fword, pword, acc_clr, step_stb, busy, done out.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int PW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] pword_in,
    output logic [FW-1:0] fword,
    output logic [PW-1:0] pword,
    output logic          acc_clr,
    output logic          step_stb,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t        state_q, state_d;
    logic          dir_dn_q, dir_dn_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fstart_q, fstart_d;
    logic [FW-1:0] fstop_q, fstop_d;
    logic [FW-1:0] fstep_q, fstep_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    mode_q, mode_d;
    logic [FW-1:0] fword_q, fword_d;
    logic [PW-1:0] pword_q, pword_d;
    logic          acc_clr_q, acc_clr_d;
    logic          step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // One extra bit so the saturating step can never wrap.
    logic [FW:0]   sum_w, dif_w;
    logic [FW-1:0] up_sat, dn_sat, nxt_f;
    logic          m_rep, m_tri;

    assign sum_w  = {1'b0, fword_q} + {1'b0, fstep_q};
    assign dif_w  = {1'b0, fword_q} - {1'b0, fstep_q};
    assign up_sat = (sum_w > {1'b0, fstop_q}) ? fstop_q : sum_w[FW-1:0];
    assign dn_sat = (dif_w[FW] || (dif_w[FW-1:0] < fstart_q)) ?
                    fstart_q : dif_w[FW-1:0];

    // Mode 11 falls through to single.
    assign m_rep = (mode_q == 2'b01);
    assign m_tri = (mode_q == 2'b10);

    always_comb begin
        state_d   = state_q;
        dir_dn_d  = dir_dn_q;
        cnt_d     = cnt_q;
        fstart_d  = fstart_q;
        fstop_d   = fstop_q;
        fstep_d   = fstep_q;
        dwell_d   = dwell_q;
        mode_d    = mode_q;
        fword_d   = fword_q;
        pword_d   = pword_q;
        acc_clr_d = 1'b0;
        step_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nxt_f     = fword_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    fstart_d  = f_start;
                    fstop_d   = (f_stop > f_start) ? f_stop : f_start;
                    fstep_d   = (f_step == '0) ? {{(FW-1){1'b0}}, 1'b1} : f_step;
                    dwell_d   = dwell;
                    mode_d    = mode;
                    fword_d   = f_start;
                    pword_d   = pword_in;
                    acc_clr_d = 1'b1;
                    busy_d    = 1'b1;
                    dir_dn_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (!dir_dn_q) begin
                        if (fword_q != fstop_q) begin
                            nxt_f = up_sat;
                        end else begin
                            unique case (1'b1)
                                m_rep: nxt_f = fstart_q;
                                m_tri: begin
                                    dir_dn_d = 1'b1;
                                    nxt_f    = dn_sat;
                                end
                                default: begin
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                    state_d = IDLE;
                                end
                            endcase
                        end
                    end else begin
                        if (fword_q != fstart_q) begin
                            nxt_f = dn_sat;
                        end else begin
                            dir_dn_d = 1'b0;
                            nxt_f    = up_sat;
                        end
                    end
                    fword_d = nxt_f;
                    // Degenerate ranges re-load the same word: no strobe.
                    step_d  = (nxt_f != fword_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_dn_q  <= 1'b0;
            cnt_q     <= '0;
            fstart_q  <= '0;
            fstop_q   <= '0;
            fstep_q   <= '0;
            dwell_q   <= '0;
            mode_q    <= '0;
            fword_q   <= '0;
            pword_q   <= '0;
            acc_clr_q <= 1'b0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_dn_q  <= dir_dn_d;
            cnt_q     <= cnt_d;
            fstart_q  <= fstart_d;
            fstop_q   <= fstop_d;
            fstep_q   <= fstep_d;
            dwell_q   <= dwell_d;
            mode_q    <= mode_d;
            fword_q   <= fword_d;
            pword_q   <= pword_d;
            acc_clr_q <= acc_clr_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign fword    = fword_q;
    assign pword    = pword_q;
    assign acc_clr  = acc_clr_q;
    assign step_stb = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps against
// a value-list model of the sweep.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  pword_in = '0;
    logic [31:0] fword;
    logic [7:0]  pword;
    logic        acc_clr, step_stb, busy, done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.FW(32), .PW(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .mode(mode), .pword_in(pword_in),
        .fword(fword), .pword(pword), .acc_clr(acc_clr),
        .step_stb(step_stb), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        f_start  = $urandom;
        f_stop   = $urandom;
        f_step   = $urandom;
        dwell    = 16'($urandom);
        mode     = 2'($urandom);
        pword_in = 8'($urandom);
    endtask

    // Sweep with the given config for ncyc cycles after start.
    // abort_at / ign_at: cycle during which abort / a stray start is raised.
    task automatic run(input logic [31:0] fs, input logic [31:0] fe,
                       input logic [31:0] fst, input int dw,
                       input logic [1:0] md, input logic [7:0] pw,
                       input int ncyc, input int abort_at,
                       input int ign_at, input string name);
        longint vals[$];
        longint s, e, st, v;
        bit     single, up, aborted;
        int     need, k, ph;
        longint ef, held;
        bit     eb, ea, es, ed;

        s  = fs;
        e  = (fe > fs) ? fe : fs;
        st = (fst == 0) ? 1 : fst;
        single = !(md == 2'b01 || md == 2'b10);
        need = ncyc / (dw + 1) + 2;
        vals.delete();
        if (single) begin
            v = s;
            vals.push_back(v);
            while (v != e && vals.size() < need + 1) begin
                v = (v + st > e) ? e : v + st;
                vals.push_back(v);
            end
        end else if (md == 2'b01) begin
            while (vals.size() < need) begin
                v = s;
                vals.push_back(v);
                while (v != e && vals.size() < need) begin
                    v = (v + st > e) ? e : v + st;
                    vals.push_back(v);
                end
            end
        end else begin
            v = s;
            up = 1'b1;
            vals.push_back(v);
            while (vals.size() < need) begin
                if (up) begin
                    if (v == e) begin
                        up = 1'b0;
                        v = (v - st < s) ? s : v - st;
                    end else begin
                        v = (v + st > e) ? e : v + st;
                    end
                end else begin
                    if (v == s) begin
                        up = 1'b1;
                        v = (v + st > e) ? e : v + st;
                    end else begin
                        v = (v - st < s) ? s : v - st;
                    end
                end
                vals.push_back(v);
            end
        end

        @(negedge clk);
        f_start = fs; f_stop = fe; f_step = fst;
        dwell = 16'(dw); mode = md; pword_in = pw;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble();

        aborted = 1'b0;
        held = s;
        for (int c = 1; c <= ncyc; c++) begin
            k  = (c - 1) / (dw + 1);
            ph = (c - 1) % (dw + 1);
            ea = 1'b0; es = 1'b0; ed = 1'b0;
            if (aborted) begin
                ef = held; eb = 1'b0;
            end else if (single && k >= vals.size()) begin
                ef = vals[vals.size() - 1];
                eb = 1'b0;
                ed = (k == vals.size() && ph == 0);
            end else begin
                ef = vals[k];
                eb = 1'b1;
                ea = (c == 1);
                es = (k > 0 && ph == 0 && vals[k] != vals[k-1]);
            end
            chk($sformatf("%s.fword@%0d", name, c), fword, 32'(ef));
            chk($sformatf("%s.pword@%0d", name, c), {24'b0, pword}, {24'b0, pw});
            chk($sformatf("%s.acc_clr@%0d", name, c), {31'b0, acc_clr}, {31'b0, ea});
            chk($sformatf("%s.step_stb@%0d", name, c), {31'b0, step_stb}, {31'b0, es});
            chk($sformatf("%s.busy@%0d", name, c), {31'b0, busy}, {31'b0, eb});
            chk($sformatf("%s.done@%0d", name, c), {31'b0, done}, {31'b0, ed});
            held = ef;
            abort = 1'b0;
            start = 1'b0;
            if (c == abort_at && eb) begin
                abort = 1'b1;
                aborted = 1'b1;
            end else if (c == ign_at && eb) begin
                scramble();
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({name, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dw, na, ni, nc;
        logic [31:0] a, b, c3;

        #1;
        chk("rst.fword", fword, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.acc_clr", {31'b0, acc_clr}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run(100, 130, 10, 3, 2'b00, 8'h5A, 22, 0, 7, "single");
        run(0, 25, 10, 0, 2'b00, 8'h11, 8, 0, 0, "sat");
        run(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 2'b00, 8'h22, 8, 0, 0, "wrap");
        run(10, 30, 10, 0, 2'b10, 8'h33, 14, 0, 0, "tri");
        run(10, 30, 10, 0, 2'b01, 8'h44, 12, 0, 0, "rep");
        run(10, 30, 10, 0, 2'b11, 8'h55, 8, 0, 0, "mode3");
        run(50, 20, 7, 2, 2'b00, 8'h66, 8, 0, 0, "rev");
        run(5, 8, 0, 1, 2'b00, 8'h77, 12, 0, 0, "step0");
        run(10, 30, 10, 2, 2'b10, 8'h88, 20, 12, 0, "abort");
        run(40, 40, 5, 1, 2'b01, 8'h99, 10, 0, 0, "degen_rep");
        run(40, 40, 5, 0, 2'b10, 8'hAA, 10, 0, 0, "degen_tri");

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        f_start = 100; f_stop = 130; f_step = 10; dwell = 3;
        mode = 2'b01; pword_in = 8'hC3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.fword", fword, 32'd0);
        chk("arst.pword", {24'b0, pword}, 32'd0);
        chk("arst.busy", {31'b0, busy}, 32'd0);
        chk("arst.step", {31'b0, step_stb}, 32'd0);
        chk("arst.done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(100, 130, 10, 3, 2'b01, 8'hC3, 10, 0, 0, "after_rst");

        for (int i = 0; i < 25; i++) begin
            dw = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = 32'hFFFF_FF00 + $urandom_range(0, 255);
                b = 32'hFFFF_FF00 + $urandom_range(0, 255);
                c3 = $urandom_range(0, 400);
            end else begin
                a = $urandom_range(0, 1000);
                b = $urandom_range(0, 1000);
                c3 = $urandom_range(0, 300);
            end
            nc = 40;
            na = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 39)) : 0;
            ni = int'($urandom_range(1, 39));
            run(a, b, c3, dw, 2'($urandom), 8'($urandom), nc, na, ni,
                $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer for the DDS phase-accumulator address generator. On a start pulse it latches a sweep configuration and steps the accumulator's frequency control word from a start value to a stop value in fixed increments, holding each value for a programmable dwell. It also presents the phase control word and a one-cycle accumulator-clear strobe at sweep start. It sits between the host/key-control logic and the phase accumulator, whose frequency and phase inputs become run-time ports driven by this block.

## Interface
- FW, 32: frequency-word width (matches the 32-bit accumulator)
- PW, 8: phase-word width (matches the 8-bit ROM address)
- DW, 16: dwell-counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; latches configuration when idle
- abort  in  1  stops an active sweep
- f_start  in  FW  first frequency word
- f_stop  in  FW  final frequency word
- f_step  in  FW  increment per step
- dwell  in  DW  hold count; each value is held dwell+1 cycles
- mode  in  2  00 single up, 01 repeat sawtooth, 10 triangle, 11 treated as 00
- pword_in  in  PW  phase word applied at sweep start
- fword  out  FW  frequency word to the accumulator
- pword  out  PW  phase word to the accumulator
- acc_clr  out  1  1-cycle pulse; the accumulator loads {pword, zeros}
- step_stb  out  1  1-cycle pulse each time fword changes during a sweep
- busy  out  1  sweep active
- done  out  1  1-cycle pulse at normal sweep completion

## Operation
- Reset values:
  - fword=0, pword=0, acc_clr=0, step_stb=0, busy=0, done=0
  - state IDLE, dir=up, dwell_cnt=0
- States: IDLE, DWELL.
- **IDLE**
  - On start=1, latch the configuration:
    - f_start_l = f_start
    - f_stop_l = max(f_start, f_stop)
    - f_step_l = (f_step==0) ? 1 : f_step
    - dwell_l, mode_l
  - In the same cycle: fword<=f_start, pword<=pword_in, acc_clr<=1, busy<=1, dir<=up, dwell_cnt<=0, state<=DWELL.
  - abort is ignored in IDLE.
- **DWELL**
  - dwell_cnt increments each cycle. On dwell_cnt==dwell_l, dwell_cnt<=0 and a step decision is taken.
  - Up, fword!=f_stop_l: fword <= min(fword+f_step_l, f_stop_l). The sum is computed at FW+1 bits, so the value saturates at stop and never wraps.
  - Down, fword!=f_start_l: fword <= max(fword-f_step_l, f_start_l). The difference is computed at FW+1 bits and saturates at start.
  - Up, fword==f_stop_l, by mode:
    - single: busy<=0, done<=1, state<=IDLE; fword holds f_stop_l so the DDS keeps running.
    - repeat: fword<=f_start_l, with no acc_clr.
    - triangle: dir<=down, fword <= max(fword-f_step_l, f_start_l).
  - Down, fword==f_start_l (triangle only): dir<=up, fword <= min(fword+f_step_l, f_stop_l).
  - Degenerate case f_start_l==f_stop_l: in repeat/triangle, fword is held constant until abort, with no step_stb.
- step_stb pulses on every step decision that changes fword. It does not pulse on the initial load.
- **abort** while busy:
  - Next state IDLE, busy<=0, fword/pword hold their current values, no done, no step_stb.
  - abort wins over a coincident step decision.
- start while busy is ignored. Configuration inputs are only sampled on an accepted start.
- Reset mid-sweep returns all outputs to their reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- start sampled at edge T: fword/pword/acc_clr/busy valid after T+1.
- Value k (k=0..N-1) is presented from cycle T+1+k·(dwell+1).
- Single mode with N distinct values: done=1 and busy=0 in cycle T+1+N·(dwell+1).
- acc_clr, step_stb and done are exactly one cycle wide.
- The earliest new start after done is the cycle done is high, since the state is already IDLE.

## Test plan
- Single sweep: f_start=100, f_stop=130, f_step=10, dwell=3, start at T.
  - fword=100@T+1, 110@T+5, 120@T+9, 130@T+13.
  - done=1 and busy=0 @T+17; fword stays 130.
  - acc_clr only @T+1; step_stb @T+5, T+9, T+13.
- Saturation: f_start=0, f_stop=25, f_step=10, dwell=0.
  - Sequence 0, 10, 20, 25, then done.
- Wrap guard: f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20.
  - Sequence 0xFFFFFFF0, 0xFFFFFFFF, then done; no wrap.
- Modes: f_start=10, f_stop=30, f_step=10, dwell=0.
  - Triangle: 10, 20, 30, 20, 10, 20, ...
  - Repeat: 10, 20, 30, 10, ... with no extra acc_clr.
  - mode=11 behaves as single.
- Edge cases:
  - f_start=50, f_stop=20 → fword=50 held for dwell+1 cycles, then done.
  - f_step=0 behaves as a step of 1.
  - start while busy is ignored.
- Abort and reset mid-sweep:
  - abort asserted on a dwell-end cycle: busy=0 next cycle, fword unchanged, no done or step_stb.
  - rst_n low mid-sweep: all outputs 0 asynchronously.
  - After release, a fresh start restarts from f_start.
